// File: rtl/video_dither_out.sv
// Board-side video output stage: 4x4 ordered dither from IN_DEPTH to OUT_DEPTH bits per
// channel, two-stage pipeline with sync/DE re-timed and re-polarised to match.
module video_dither_out #(
    parameter int unsigned IN_DEPTH   = 6,
    parameter int unsigned OUT_DEPTH  = 1,
    parameter logic        HS_POL_IN  = 1'b1,
    parameter logic        VS_POL_IN  = 1'b1,
    parameter logic        HS_POL_OUT = 1'b1,
    parameter logic        VS_POL_OUT = 1'b1,
    parameter int unsigned TEMPORAL   = 1,
    parameter int unsigned RGB_ORDER  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [IN_DEPTH-1:0]    in_r,
    input  logic [IN_DEPTH-1:0]    in_g,
    input  logic [IN_DEPTH-1:0]    in_b,
    input  logic                   in_hs,
    input  logic                   in_vs,
    input  logic                   in_de,
    input  logic                   dither_en,
    output logic [3*OUT_DEPTH-1:0] rgb,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   out_de
);

    localparam int unsigned SHIFT = IN_DEPTH - OUT_DEPTH;
    localparam int unsigned SH_L  = (SHIFT >= 4) ? SHIFT - 4 : 0;
    localparam int unsigned SH_R  = (SHIFT < 4) ? 4 - SHIFT : 0;
    localparam logic [IN_DEPTH:0] O_MAX = (IN_DEPTH + 1)'((1 << OUT_DEPTH) - 1);

    // sync edge detection and pixel position counters
    logic                hs_act, vs_act, hs_edge, vs_edge;
    logic                hs_prev_q, hs_prev_d;
    logic                vs_prev_q, vs_prev_d;
    logic [1:0]          x_q, x_d;
    logic [1:0]          y_q, y_d;
    logic [1:0]          frame_q, frame_d;

    // stage 1
    logic [IN_DEPTH-1:0] r1_q, r1_d;
    logic [IN_DEPTH-1:0] g1_q, g1_d;
    logic [IN_DEPTH-1:0] b1_q, b1_d;
    logic [IN_DEPTH-1:0] t1_q, t1_d;
    logic                de1_q, de1_d;
    logic                hs1_q, hs1_d;
    logic                vs1_q, vs1_d;

    // stage 2
    logic [3*OUT_DEPTH-1:0] rgb_q, rgb_d;
    logic                   de2_q, de2_d;
    logic                   hs2_q, hs2_d;
    logic                   vs2_q, vs2_d;

    // threshold datapath
    logic [1:0]          xi;
    logic [3:0]          m_val;
    logic [11:0]         m_scaled;
    logic [OUT_DEPTH-1:0] r_o, g_o, b_o;

    function automatic logic [3:0] bayer(input logic [1:0] yy, input logic [1:0] xx);
        logic [3:0] m;
        case ({yy, xx})
            4'd0:  m = 4'd0;
            4'd1:  m = 4'd8;
            4'd2:  m = 4'd2;
            4'd3:  m = 4'd10;
            4'd4:  m = 4'd12;
            4'd5:  m = 4'd4;
            4'd6:  m = 4'd14;
            4'd7:  m = 4'd6;
            4'd8:  m = 4'd3;
            4'd9:  m = 4'd11;
            4'd10: m = 4'd1;
            4'd11: m = 4'd9;
            4'd12: m = 4'd15;
            4'd13: m = 4'd7;
            4'd14: m = 4'd13;
            default: m = 4'd5;
        endcase
        return m;
    endfunction

    // Sum is one bit wider than the input so a full-scale value plus threshold cannot wrap.
    function automatic logic [OUT_DEPTH-1:0] quant(input logic [IN_DEPTH-1:0] v,
                                                   input logic [IN_DEPTH-1:0] t);
        logic [IN_DEPTH:0] sum;
        logic [IN_DEPTH:0] shf;
        sum = {1'b0, v} + {1'b0, t};
        shf = sum >> SHIFT;
        if (shf > O_MAX) begin
            return '1;
        end
        return shf[OUT_DEPTH-1:0];
    endfunction

    always_comb begin
        hs_act  = (in_hs == HS_POL_IN);
        vs_act  = (in_vs == VS_POL_IN);
        hs_edge = hs_act & ~hs_prev_q;
        vs_edge = vs_act & ~vs_prev_q;

        hs_prev_d = hs_act;
        vs_prev_d = vs_act;

        if (hs_edge) begin
            x_d = '0;
        end else if (in_de) begin
            x_d = x_q + 2'd1;
        end else begin
            x_d = x_q;
        end

        if (vs_edge) begin
            y_d = '0;
        end else if (hs_edge) begin
            y_d = y_q + 2'd1;
        end else begin
            y_d = y_q;
        end

        if (TEMPORAL == 0) begin
            frame_d = '0;
        end else if (vs_edge) begin
            frame_d = frame_q + 2'd1;
        end else begin
            frame_d = frame_q;
        end
    end

    always_comb begin
        xi    = x_q + frame_q;
        m_val = bayer(y_q, xi);
        if (SHIFT >= 4) begin
            m_scaled = 12'(m_val) << SH_L;
        end else begin
            m_scaled = 12'(m_val) >> SH_R;
        end

        r1_d  = in_r;
        g1_d  = in_g;
        b1_d  = in_b;
        de1_d = in_de;
        hs1_d = hs_act;
        vs1_d = vs_act;
        if (dither_en && (SHIFT != 0)) begin
            t1_d = m_scaled[IN_DEPTH-1:0];
        end else begin
            t1_d = '0;
        end
    end

    always_comb begin
        r_o = '0;
        g_o = '0;
        b_o = '0;
        if (de1_q) begin
            r_o = quant(r1_q, t1_q);
            g_o = quant(g1_q, t1_q);
            b_o = quant(b1_q, t1_q);
        end

        if (RGB_ORDER == 0) begin
            rgb_d = {b_o, g_o, r_o};
        end else begin
            rgb_d = {r_o, g_o, b_o};
        end
        de2_d = de1_q;
        hs2_d = hs1_q;
        vs2_d = vs1_q;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hs_prev_q <= 1'b0;
            vs_prev_q <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            frame_q   <= '0;
            r1_q      <= '0;
            g1_q      <= '0;
            b1_q      <= '0;
            t1_q      <= '0;
            de1_q     <= 1'b0;
            hs1_q     <= 1'b0;
            vs1_q     <= 1'b0;
            rgb_q     <= '0;
            de2_q     <= 1'b0;
            hs2_q     <= 1'b0;
            vs2_q     <= 1'b0;
        end else begin
            hs_prev_q <= hs_prev_d;
            vs_prev_q <= vs_prev_d;
            x_q       <= x_d;
            y_q       <= y_d;
            frame_q   <= frame_d;
            r1_q      <= r1_d;
            g1_q      <= g1_d;
            b1_q      <= b1_d;
            t1_q      <= t1_d;
            de1_q     <= de1_d;
            hs1_q     <= hs1_d;
            vs1_q     <= vs1_d;
            rgb_q     <= rgb_d;
            de2_q     <= de2_d;
            hs2_q     <= hs2_d;
            vs2_q     <= vs2_d;
        end
    end

    assign rgb    = rgb_q;
    assign out_de = de2_q;
    assign hsync  = hs2_q ? HS_POL_OUT : ~HS_POL_OUT;
    assign vsync  = vs2_q ? VS_POL_OUT : ~VS_POL_OUT;

endmodule

// File: tb/tb_video_dither_out.sv
// Scoreboard bench for video_dither_out: four differently configured instances share one
// randomized/directed stimulus stream and are checked against an arithmetic reference model.
module tb_video_dither_out;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] in_r, in_g, in_b;
    logic       in_hs, in_vs, in_de, dither_en;

    logic [2:0]  rgb0, rgb1;
    logic [11:0] rgb2;
    logic [8:0]  rgb3;
    logic        hs0, hs1, hs2, hs3;
    logic        vs0, vs1, vs2, vs3;
    logic        de0, de1, de2, de3;

    // u0: defaults; u1: no temporal, inverted hsync, {r,g,b}; u2: 4->4 pass-through; u3: 5->3
    video_dither_out u0 (
        .clk(clk), .reset(reset), .in_r(in_r[5:0]), .in_g(in_g[5:0]), .in_b(in_b[5:0]),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .dither_en(dither_en),
        .rgb(rgb0), .hsync(hs0), .vsync(vs0), .out_de(de0));

    video_dither_out #(.TEMPORAL(0), .HS_POL_OUT(1'b0), .RGB_ORDER(1)) u1 (
        .clk(clk), .reset(reset), .in_r(in_r[5:0]), .in_g(in_g[5:0]), .in_b(in_b[5:0]),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .dither_en(dither_en),
        .rgb(rgb1), .hsync(hs1), .vsync(vs1), .out_de(de1));

    video_dither_out #(.IN_DEPTH(4), .OUT_DEPTH(4), .TEMPORAL(0)) u2 (
        .clk(clk), .reset(reset), .in_r(in_r[3:0]), .in_g(in_g[3:0]), .in_b(in_b[3:0]),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .dither_en(dither_en),
        .rgb(rgb2), .hsync(hs2), .vsync(vs2), .out_de(de2));

    video_dither_out #(.IN_DEPTH(5), .OUT_DEPTH(3), .VS_POL_OUT(1'b0), .RGB_ORDER(1)) u3 (
        .clk(clk), .reset(reset), .in_r(in_r[4:0]), .in_g(in_g[4:0]), .in_b(in_b[4:0]),
        .in_hs(in_hs), .in_vs(in_vs), .in_de(in_de), .dither_en(dither_en),
        .rgb(rgb3), .hsync(hs3), .vsync(vs3), .out_de(de3));

    function automatic int in_d(int i);
        case (i) 0: return 6; 1: return 6; 2: return 4; default: return 5; endcase
    endfunction
    function automatic int out_d(int i);
        case (i) 0: return 1; 1: return 1; 2: return 4; default: return 3; endcase
    endfunction
    function automatic bit temporal(int i);
        return (i == 0) || (i == 3);
    endfunction
    function automatic bit order_rgb(int i);
        return (i == 1) || (i == 3);
    endfunction
    function automatic bit hs_pol_out(int i);
        return i != 1;
    endfunction
    function automatic bit vs_pol_out(int i);
        return i != 3;
    endfunction

    function automatic int bayer_m(int yy, int xx);
        int m [16];
        m = '{0, 8, 2, 10, 12, 4, 14, 6, 3, 11, 1, 9, 15, 7, 13, 5};
        return m[yy * 4 + xx];
    endfunction

    function automatic int quant(int v, int t, int s, int od);
        int o;
        o = (v + t) / (1 << s);
        if (o > (1 << od) - 1) o = (1 << od) - 1;
        return o;
    endfunction

    typedef struct packed {
        logic [1:0]       tag;
        logic [3:0]       de;
        logic [3:0]       hs;
        logic [3:0]       vs;
        logic [3:0][11:0] rgb;
    } exp_t;

    exp_t sb_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   lit_blk = 0;
    int   lit_tmp = 0;

    // reference pixel position: columns since the line start, lines since frame start, frame count
    int   mx, my, mf;
    bit   m_hsp, m_vsp;

    task automatic drive(input bit rst, input bit hs, input bit vs, input bit de, input bit den,
                         input logic [7:0] r, input logic [7:0] g, input logic [7:0] b,
                         input logic [1:0] tag);
        exp_t e, rst_e, prev;
        int   s, t, m, xi, od, id, o_r, o_g, o_b, pk;
        bit   hs_edge, vs_edge;
        @(negedge clk);
        reset = rst; in_hs = hs; in_vs = vs; in_de = de; dither_en = den;
        in_r = r; in_g = g; in_b = b;

        rst_e = '0;
        for (int i = 0; i < 4; i++) begin
            rst_e.hs[i] = !hs_pol_out(i);
            rst_e.vs[i] = !vs_pol_out(i);
        end

        if (!rst) begin
            // reset also flushes the pixel already sitting in the first stage
            e = rst_e;
            e.tag = tag;
            if (sb_q.size() > 0) begin
                prev = rst_e;
                prev.tag = sb_q[sb_q.size() - 1].tag;
                sb_q[sb_q.size() - 1] = prev;
            end
            mx = 0; my = 0; mf = 0; m_hsp = 0; m_vsp = 0;
        end else begin
            e = '0;
            e.tag = tag;
            for (int i = 0; i < 4; i++) begin
                id = in_d(i);
                od = out_d(i);
                s  = id - od;
                xi = (mx + (temporal(i) ? mf : 0)) % 4;
                m  = bayer_m(my, xi);
                t  = (!den || s == 0) ? 0 : (m * (1 << s)) / 16;
                o_r = de ? quant(int'(r) % (1 << id), t, s, od) : 0;
                o_g = de ? quant(int'(g) % (1 << id), t, s, od) : 0;
                o_b = de ? quant(int'(b) % (1 << id), t, s, od) : 0;
                if (order_rgb(i)) pk = (o_r << (2 * od)) | (o_g << od) | o_b;
                else              pk = (o_b << (2 * od)) | (o_g << od) | o_r;
                e.rgb[i] = 12'(pk);
                e.hs[i]  = hs ? hs_pol_out(i) : !hs_pol_out(i);
                e.vs[i]  = vs ? vs_pol_out(i) : !vs_pol_out(i);
                e.de[i]  = de;
            end
            hs_edge = hs && !m_hsp;
            vs_edge = vs && !m_vsp;
            if (hs_edge) mx = 0;
            else if (de) mx = (mx + 1) % 4;
            if (vs_edge) begin
                my = 0;
                mf = (mf + 1) % 4;
            end else if (hs_edge) begin
                my = (my + 1) % 4;
            end
            m_hsp = hs;
            m_vsp = vs;
        end
        sb_q.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
    endtask

    exp_t       mon_e;
    logic [14:0] act_v [4];
    logic [14:0] exp_v;

    always @(posedge clk) begin
        #1;
        if (sb_q.size() >= 2) begin
            mon_e = sb_q.pop_front();
            act_v[0] = {de0, hs0, vs0, 12'(rgb0)};
            act_v[1] = {de1, hs1, vs1, 12'(rgb1)};
            act_v[2] = {de2, hs2, vs2, rgb2};
            act_v[3] = {de3, hs3, vs3, 12'(rgb3)};
            for (int i = 0; i < 4; i++) begin
                exp_v = {mon_e.de[i], mon_e.hs[i], mon_e.vs[i], mon_e.rgb[i]};
                n_tests++;
                if (act_v[i] !== exp_v) begin
                    n_fail++;
                    $display("FAIL u%0d pixel @%0t: de/hs/vs/rgb got %b/%b/%b/%h expected %b/%b/%b/%h",
                             i, $time, act_v[i][14], act_v[i][13], act_v[i][12], act_v[i][11:0],
                             exp_v[14], exp_v[13], exp_v[12], exp_v[11:0]);
                end
            end
            if (mon_e.tag == 2'd1 && rgb1 == 3'b111) lit_blk++;
            if (mon_e.tag == 2'd2 && rgb0 == 3'b111) lit_tmp++;
        end
    end

    initial begin
        reset = 1'b0; in_r = '0; in_g = '0; in_b = '0;
        in_hs = 1'b0; in_vs = 1'b0; in_de = 1'b0; dither_en = 1'b0;
        mx = 0; my = 0; mf = 0; m_hsp = 0; m_vsp = 0;

        // reset held with random inputs
        for (int k = 0; k < 3; k++)
            drive(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), 8'($urandom), 8'($urandom), 2'd0);
        idle(2);

        // 4->4 pass-through with and without dither, plus a one-cycle hsync pulse
        drive(1, 0, 0, 1, 0, 8'h0A, 8'h05, 8'h0F, 2'd0);
        drive(1, 0, 0, 1, 1, 8'h0A, 8'h03, 8'h00, 2'd0);
        drive(1, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        idle(2);

        // 4x4 block at v=16 with a fixed matrix
        drive(1, 1, 1, 0, 1, 8'd16, 8'd16, 8'd16, 2'd0);
        for (int ln = 0; ln < 4; ln++) begin
            if (ln > 0) drive(1, 1, 0, 0, 1, 8'd16, 8'd16, 8'd16, 2'd0);
            for (int p = 0; p < 4; p++) drive(1, 0, 0, 1, 1, 8'd16, 8'd16, 8'd16, 2'd1);
            idle(1);
        end

        // full scale, zero, truncation, and blanking of a full-scale value
        for (int k = 0; k < 6; k++) drive(1, 0, 0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0);
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 1, 1, 8'h00, 8'h00, 8'h00, 2'd0);
        for (int k = 0; k < 4; k++) drive(1, 0, 0, 1, 0, 8'd31, 8'd31, 8'd31, 2'd0);
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 1, 8'h3F, 8'h3F, 8'h3F, 2'd0);

        // same pixel over four frames with the temporal offset
        idle(1);
        for (int f = 0; f < 4; f++) begin
            drive(1, 1, 1, 0, 1, 8'd16, 8'd16, 8'd16, 2'd0);
            drive(1, 0, 0, 1, 1, 8'd16, 8'd16, 8'd16, 2'd2);
            idle(2);
        end

        // reset asserted in the middle of a line
        for (int k = 0; k < 3; k++) drive(1, 0, 0, 1, 1, 8'hFF, 8'h20, 8'h1C, 2'd0);
        drive(0, 0, 0, 1, 1, 8'hFF, 8'hFF, 8'hFF, 2'd0);
        idle(2);

        // randomized traffic with occasional resets
        for (int k = 0; k < 2000; k++)
            drive(($urandom % 97) != 0, ($urandom % 6) == 0, ($urandom % 40) == 0,
                  ($urandom % 4) != 0, ($urandom % 4) != 0,
                  8'($urandom), 8'($urandom), 8'($urandom), 2'd0);

        idle(4);
        @(posedge clk);
        #2;

        n_tests++;
        if (lit_blk != 8) begin
            n_fail++;
            $display("FAIL block_lit_count: got %0d required 8", lit_blk);
        end
        n_tests++;
        if (lit_tmp != 2) begin
            n_fail++;
            $display("FAIL temporal_lit_count: got %0d required 2", lit_tmp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
